// File: rtl/aes_shift_mix_stage.sv
// AES forward round back-end: ShiftRows, MixColumns, AddRoundKey.
// Elastic valid/ready stage with a DEPTH-entry output buffer.
module aes_shift_mix_stage #(
  parameter int DEPTH   = 2,
  parameter bit USE_KEY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] IN_DATA,
  input  logic [127:0] ROUND_KEY,
  input  logic         LAST_ROUND,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA,
  output logic         OUT_LAST
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] d);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = d[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] result;

  logic [128:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          in_ready_q;
  logic          push, pop;
  logic          out_valid;

  // Round datapath ahead of the buffer write.
  always_comb begin
    shifted = shift_rows(IN_DATA);
    mixed   = shifted;
    if (!LAST_ROUND) begin
      for (int c = 0; c < 4; c++) begin
        mixed[127-32*c -: 32] = mix_col(shifted[127-32*c -: 32]);
      end
    end
    result = USE_KEY ? (mixed ^ ROUND_KEY) : mixed;
  end

  assign out_valid = (count_q != '0);
  assign push      = IN_VALID & in_ready_q;
  assign pop       = out_valid & OUT_READY;

  // Next-state pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Buffer control state; ready is registered from next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      in_ready_q <= (count_d != FULL);
    end
  end

  // Buffer storage: {last, data}.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {LAST_ROUND, result};
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid;
  assign OUT_DATA  = out_valid ? mem_q[rptr_q][127:0] : '0;
  assign OUT_LAST  = out_valid ? mem_q[rptr_q][128] : 1'b0;

endmodule

// File: tb/tb_aes_shift_mix_stage.sv
// Self-checking bench for aes_shift_mix_stage.
// Fixed vectors, streamed random beats against a byte-matrix model.
module tb_aes_shift_mix_stage;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [127:0] IN_DATA = '0;
  logic [127:0] ROUND_KEY = '0;
  logic         LAST_ROUND = 1'b0;
  logic         OUT_VALID;
  logic         OUT_READY = 1'b0;
  logic [127:0] OUT_DATA;
  logic         OUT_LAST;

  int nvec = 0;
  int nerr = 0;

  aes_shift_mix_stage #(.DEPTH(DEPTH), .USE_KEY(1'b1)) dut (
    .clk(clk), .rst(rst),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .ROUND_KEY(ROUND_KEY),
    .LAST_ROUND(LAST_ROUND),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [128:0] act,
                     input logic [128:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // GF(2^8) multiply by shift-and-add with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // State as a 4x4 byte matrix s[row][col], byte index 4*col+row.
  function automatic logic [127:0] ref_round(input logic [127:0] d,
                                             input logic [127:0] k,
                                             input logic last);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] m [4][4];
    int coef [4][4];
    logic [127:0] o;
    coef = '{'{2,3,1,1}, '{1,2,3,1}, '{1,1,2,3}, '{3,1,1,2}};
    for (int i = 0; i < 16; i++) s[i%4][i/4] = d[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = s[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (last) m[r][c] = t[r][c];
        else begin
          m[r][c] = 8'h00;
          for (int j = 0; j < 4; j++)
            m[r][c] = m[r][c] ^ gmul(t[j][c], coef[r][j]);
        end
      end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i%4][i/4];
    return o ^ k;
  endfunction

  typedef struct {
    logic [127:0] din;
    logic [127:0] key;
    logic         last;
    logic [127:0] dout;
  } vec_t;

  vec_t tv [4];

  // mode 0: stall 4 cycles; mode 1: always ready; mode 2: random.
  task automatic run_stream(input int n, input int mode);
    logic [127:0] bd [$];
    logic [127:0] bk [$];
    logic         bl [$];
    logic [128:0] q [$];
    int idx = 0, got = 0, cyc = 0, first = -1, lastc = -1, maxq = 0;
    logic rdy;
    for (int i = 0; i < n; i++) begin
      bd.push_back({$urandom, $urandom, $urandom, $urandom});
      bk.push_back({$urandom, $urandom, $urandom, $urandom});
      bl.push_back(1'($urandom_range(0, 1)));
    end
    while ((idx < n || q.size() != 0) && cyc < 400) begin
      @(negedge clk);
      chk("out_valid", 129'(OUT_VALID), 129'(q.size() != 0));
      chk("in_ready", 129'(IN_READY), 129'(q.size() != DEPTH));
      if (q.size() != 0) chk("out_beat", {OUT_LAST, OUT_DATA}, q[0]);
      rdy = (mode == 0) ? (cyc >= 4) :
            (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      OUT_READY = rdy;
      if (OUT_VALID && rdy && q.size() != 0) begin
        void'(q.pop_front());
        got++;
        if (first < 0) first = cyc;
        lastc = cyc;
      end
      IN_VALID = (idx < n) && (mode != 2 || $urandom_range(0, 1) == 1);
      if (idx < n) begin
        IN_DATA    = bd[idx];
        ROUND_KEY  = bk[idx];
        LAST_ROUND = bl[idx];
      end
      if (IN_VALID && IN_READY) begin
        q.push_back({bl[idx], ref_round(bd[idx], bk[idx], bl[idx])});
        idx++;
      end
      if (q.size() > maxq) maxq = q.size();
      cyc++;
    end
    @(negedge clk);
    IN_VALID = 1'b0;
    chk("stream_timeout", 129'(cyc >= 400), 129'(0));
    chk("delivered", 129'(got), 129'(n));
    chk("drained", 129'(OUT_VALID), 129'(0));
    if (mode == 1) begin
      chk("tput_span", 129'(lastc - first + 1), 129'(n));
      chk("tput_maxq", 129'(maxq), 129'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{128'hdbc6015c_f213c601_010a53c6_c6012245, 128'h0, 1'b0,
              128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
    tv[1] = '{128'hd42711ae_e0bf98f1_b8b45de5_1e415230,
              128'ha0fafe17_88542cb1_23a33939_2a6c7605, 1'b0,
              128'ha49c7ff2_689f352b_6b5bea43_026a5049};
    tv[2] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0, 1'b1,
              128'h00050a0f_04090e03_080d0207_0c01060b};
    tv[3] = '{128'h0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b1,
              128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};

    #1;
    chk("rst_out_valid", 129'(OUT_VALID), 129'(0));
    chk("rst_in_ready", 129'(IN_READY), 129'(0));
    chk("rst_out_data", {OUT_LAST, OUT_DATA}, 129'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 129'(IN_READY), 129'(1));

    OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      IN_VALID   = 1'b1;
      IN_DATA    = tv[i].din;
      ROUND_KEY  = tv[i].key;
      LAST_ROUND = tv[i].last;
      @(posedge clk);
      #1;
      IN_VALID = 1'b0;
      chk("vec_valid", 129'(OUT_VALID), 129'(1));
      chk("vec_beat", {OUT_LAST, OUT_DATA}, {tv[i].last, tv[i].dout});
      chk("vec_model", 129'(ref_round(tv[i].din, tv[i].key, tv[i].last)),
          129'(tv[i].dout));
      @(posedge clk);
      #1;
      chk("vec_popped", 129'(OUT_VALID), 129'(0));
    end

    run_stream(6, 0);
    run_stream(16, 1);
    run_stream(40, 2);

    @(negedge clk);
    OUT_READY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IN_VALID   = 1'b1;
      IN_DATA    = {$urandom, $urandom, $urandom, $urandom};
      ROUND_KEY  = '0;
      LAST_ROUND = 1'b1;
      @(negedge clk);
    end
    IN_VALID = 1'b0;
    chk("pre_rst_valid", 129'(OUT_VALID), 129'(1));
    chk("pre_rst_full", 129'(IN_READY), 129'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 129'(OUT_VALID), 129'(0));
    chk("mid_rst_ready", 129'(IN_READY), 129'(0));
    chk("mid_rst_data", {OUT_LAST, OUT_DATA}, 129'(0));
    @(negedge clk);
    rst = 1'b0;
    OUT_READY = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 129'(IN_READY), 129'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale", 129'(OUT_VALID), 129'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
